// File: rtl/rshift_pkg.sv
// Shared constants for the round-robin right-shift arbiter.
package rshift_pkg;
   localparam int   DW       = 8;
   localparam int   SW       = 3;
   localparam logic TAG_REQ0 = 1'b0;
   localparam logic TAG_REQ1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter, purely combinational; the caller owns last_grant.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_idx
);
   import rshift_pkg::*;

   always_comb begin
      gnt_idx = TAG_REQ0;
      if (req == 2'b11)
         gnt_idx = ~last_grant;
      else if (req[1])
         gnt_idx = TAG_REQ1;

      gnt = 2'b00;
      if (en && (|req))
         gnt = gnt_idx ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/rshift_arbiter_8.sv
// Two requesters share one 8-bit right shifter behind a registered output slot.
// Define RSHIFT_ARB_ROTATE_EN to add per-request rotate-right (in0_rot/in1_rot).
module rshift_arbiter_8 #(
   parameter int DW = rshift_pkg::DW,
   parameter int SW = rshift_pkg::SW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in0_valid,
   output logic          in0_ready,
   input  logic [DW-1:0] in0_data,
   input  logic [SW-1:0] in0_sel,
   input  logic          in1_valid,
   output logic          in1_ready,
   input  logic [DW-1:0] in1_data,
   input  logic [SW-1:0] in1_sel,
`ifdef RSHIFT_ARB_ROTATE_EN
   input  logic          in0_rot,
   input  logic          in1_rot,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_tag
);
   import rshift_pkg::*;

   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_out_tag;
   logic          r_last_grant;

   logic          w_free;
   logic [1:0]    w_gnt;
   logic          w_idx;
   logic          w_accept;
   logic [DW-1:0] w_data;
   logic [SW-1:0] w_sel;
   logic [DW-1:0] w_res;

   // The slot can take a new result if it is empty or being drained this cycle.
   assign w_free = !r_out_valid || out_ready;

   rr_arb2 u_arb (
      .req        ({in1_valid, in0_valid}),
      .last_grant (r_last_grant),
      .en         (w_free),
      .gnt        (w_gnt),
      .gnt_idx    (w_idx)
   );

   assign in0_ready = w_gnt[0];
   assign in1_ready = w_gnt[1];
   assign w_accept  = |w_gnt;
   assign w_data    = w_idx ? in1_data : in0_data;
   assign w_sel     = w_idx ? in1_sel  : in0_sel;

`ifdef RSHIFT_ARB_ROTATE_EN
   logic            w_rot;
   logic [2*DW-1:0] w_dbl;

   // Shifting the doubled operand leaves the rotate-right in the low half.
   assign w_rot = w_idx ? in1_rot : in0_rot;
   assign w_dbl = {w_data, w_data} >> w_sel;
   assign w_res = w_rot ? w_dbl[DW-1:0] : (w_data >> w_sel);
`else
   assign w_res = w_data >> w_sel;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_tag    <= TAG_REQ0;
         r_last_grant <= TAG_REQ1;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= w_res;
         r_out_tag    <= w_idx;
         r_last_grant <= w_idx;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_tag   = r_out_tag;
endmodule

// File: tb/tb_rshift_arbiter_8.sv
// Scoreboard bench for rshift_arbiter_8; rotate cases run when RSHIFT_ARB_ROTATE_EN is defined.
module tb_rshift_arbiter_8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in0_valid = 1'b0, in1_valid = 1'b0;
   logic       in0_ready, in1_ready;
   logic [7:0] in0_data = 8'h00, in1_data = 8'h00;
   logic [2:0] in0_sel = 3'd0, in1_sel = 3'd0;
`ifdef RSHIFT_ARB_ROTATE_EN
   logic       in0_rot = 1'b0, in1_rot = 1'b0;
`endif
   logic       out_valid, out_ready = 1'b0, out_tag;
   logic [7:0] out_data;

   typedef struct {
      logic       tag;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rshift_arbiter_8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in0_sel   (in0_sel),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .in1_sel   (in1_sel),
`ifdef RSHIFT_ARB_ROTATE_EN
      .in0_rot   (in0_rot),
      .in1_rot   (in1_rot),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   task automatic test_reset;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 1'b0 || in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset: got v=%b d=%h t=%b rdy=%b%b, want v=0 d=00 t=0 rdy=00",
                  out_valid, out_data, out_tag, in1_ready, in0_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single0;
      @(negedge clk);
      in0_valid = 1'b1; in0_data = 8'hA5; in0_sel = 3'd1; out_ready = 1'b1;
      #1;
      checks++;
      if ({in1_ready, in0_ready} !== 2'b01) begin
         errors++; $display("FAIL single0_ready: got %b want 01", {in1_ready, in0_ready});
      end
      q.push_back('{1'b0, 8'h52});
      @(negedge clk);
      in0_valid = 1'b0;
      #1;
      if (q.size() > 0) begin
         e = q[0]; checks++;
         if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
            errors++; $display("FAIL single0_out: got v=%b t=%b d=%h want t=%b d=%h", out_valid, out_tag, out_data, e.tag, e.data);
         end
         if (out_ready) void'(q.pop_front());
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single0_drop: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_in1_only;
      logic [2:0] sels [2];
      logic [7:0] res  [2];
      sels[0] = 3'd3; res[0] = 8'h14;
      sels[1] = 3'd7; res[1] = 8'h01;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in1_valid = (i < 2); in1_data = 8'hA5;
         if (i < 2) in1_sel = sels[i];
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL in1_out: got v=%b t=%b d=%h want t=%b d=%h", out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (i < 2) begin
            checks++;
            if ({in1_ready, in0_ready} !== 2'b10) begin
               errors++; $display("FAIL in1_ready: got %b want 10", {in1_ready, in0_ready});
            end
            q.push_back('{1'b1, res[i]});
         end
      end
   endtask

   task automatic test_both;
      logic [1:0] want;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in0_valid = (i < 4); in0_data = 8'hFF; in0_sel = 3'd4;
         in1_valid = (i < 4); in1_data = 8'h80; in1_sel = 3'd7;
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL both_out: got v=%b t=%b d=%h want t=%b d=%h", out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (i < 4) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({in1_ready, in0_ready} !== want) begin
               errors++; $display("FAIL both_ready[%0d]: got %b want %b", i, {in1_ready, in0_ready}, want);
            end
            if (i % 2 == 0) q.push_back('{1'b0, 8'h0F});
            else            q.push_back('{1'b1, 8'h01});
         end
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || q.size() != 0) begin
         errors++; $display("FAIL both_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, q.size());
      end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      in0_valid = 1'b1; in0_data = 8'h3C; in0_sel = 3'd2; out_ready = 1'b1;
      #1;
      checks++;
      if ({in1_ready, in0_ready} !== 2'b01) begin
         errors++; $display("FAIL bp_first_ready: got %b want 01", {in1_ready, in0_ready});
      end
      q.push_back('{1'b0, 8'h0F});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         out_ready = 1'b0; in1_valid = 1'b1; in1_data = 8'hF0; in1_sel = 3'd1;
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL bp_hold[%0d]: got v=%b t=%b d=%h want t=%b d=%h", i, out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         checks++;
         if ({in1_ready, in0_ready} !== 2'b00) begin
            errors++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {in1_ready, in0_ready});
         end
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         if (i == 1) begin in0_valid = 1'b0; in1_valid = 1'b0; end
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL bp_out[%0d]: got v=%b t=%b d=%h want t=%b d=%h", i, out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (i == 0) begin
            checks++;
            if ({in1_ready, in0_ready} !== 2'b10) begin
               errors++; $display("FAIL bp_release_ready: got %b want 10", {in1_ready, in0_ready});
            end
            q.push_back('{1'b1, 8'h78});
         end
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || q.size() != 0) begin
         errors++; $display("FAIL bp_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, q.size());
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      in0_valid = 1'b1; in0_data = 8'hA5; in0_sel = 3'd0; out_ready = 1'b1;
      #1;
      checks++;
      if ({in1_ready, in0_ready} !== 2'b01) begin
         errors++; $display("FAIL rmid_ready: got %b want 01", {in1_ready, in0_ready});
      end
      q.push_back('{1'b0, 8'hA5});
      @(negedge clk);
      in0_valid = 1'b0; out_ready = 1'b0;
      #1;
      if (q.size() > 0) begin
         e = q[0]; checks++;
         if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
            errors++; $display("FAIL rmid_sel0_out: got v=%b t=%b d=%h want t=%b d=%h", out_valid, out_tag, out_data, e.tag, e.data);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_tag !== 1'b0) begin
         errors++; $display("FAIL rmid_async: got v=%b d=%h t=%b want v=0 d=00 t=0", out_valid, out_data, out_tag);
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      in0_valid = 1'b1; in0_data = 8'h81; in0_sel = 3'd7;
      in1_valid = 1'b1; in1_data = 8'h81; in1_sel = 3'd0;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({in1_ready, in0_ready} !== 2'b01) begin
         errors++; $display("FAIL rmid_first_grant: got %b want 01", {in1_ready, in0_ready});
      end
      q.push_back('{1'b0, 8'h01});
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in0_valid = 1'b0;
         if (i == 1) in1_valid = 1'b0;
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL rmid_out[%0d]: got v=%b t=%b d=%h want t=%b d=%h", i, out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (i == 0) begin
            checks++;
            if ({in1_ready, in0_ready} !== 2'b10) begin
               errors++; $display("FAIL rmid_in1_ready: got %b want 10", {in1_ready, in0_ready});
            end
            q.push_back('{1'b1, 8'h81});
         end
      end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || q.size() != 0) begin
         errors++; $display("FAIL rmid_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, q.size());
      end
   endtask

`ifdef RSHIFT_ARB_ROTATE_EN
   task automatic test_rotate;
      logic [2:0] sels [4];
      logic       rots [4];
      logic [7:0] res  [4];
      sels[0] = 3'd1; rots[0] = 1'b1; res[0] = 8'hD2;
      sels[1] = 3'd0; rots[1] = 1'b1; res[1] = 8'hA5;
      sels[2] = 3'd4; rots[2] = 1'b1; res[2] = 8'h5A;
      sels[3] = 3'd4; rots[3] = 1'b0; res[3] = 8'h0A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in0_valid = (i < 4); in0_data = 8'hA5; out_ready = 1'b1;
         if (i < 4) begin in0_sel = sels[i]; in0_rot = rots[i]; end
         #1;
         if (q.size() > 0) begin
            e = q[0]; checks++;
            if (out_valid !== 1'b1 || out_tag !== e.tag || out_data !== e.data) begin
               errors++; $display("FAIL rot_out[%0d]: got v=%b t=%b d=%h want t=%b d=%h", i, out_valid, out_tag, out_data, e.tag, e.data);
            end
            if (out_ready) void'(q.pop_front());
         end
         if (i < 4) begin
            checks++;
            if ({in1_ready, in0_ready} !== 2'b01) begin
               errors++; $display("FAIL rot_ready[%0d]: got %b want 01", i, {in1_ready, in0_ready});
            end
            q.push_back('{1'b0, res[i]});
         end
      end
      in0_rot = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single0();
      test_in1_only();
      test_both();
      test_backpressure();
      test_reset_mid();
`ifdef RSHIFT_ARB_ROTATE_EN
      test_rotate();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
